// File: rtl/digit_entry_controller_pkg.sv
// Shared types for the digit entry controller.
//   state_t    : sequencer states
//   evt_t      : encoded button event, higher value wins when events coincide
//   encode_evt : collapses three simultaneous rising edges into one event
package digit_entry_pkg;

  typedef enum logic [1:0] {
    EMPTY    = 2'd0,
    ENTRY    = 2'd1,
    FULL     = 2'd2,
    CLEARING = 2'd3
  } state_t;

  typedef logic [1:0] evt_t;

  localparam evt_t EVT_NONE  = 2'd0;
  localparam evt_t EVT_ENTER = 2'd1;
  localparam evt_t EVT_BACK  = 2'd2;
  localparam evt_t EVT_CLEAR = 2'd3;

  // clear > back > enter; losers on the same edge are discarded.
  function automatic evt_t encode_evt(input logic clr, input logic back, input logic enter);
    if (clr)        return EVT_CLEAR;
    else if (back)  return EVT_BACK;
    else if (enter) return EVT_ENTER;
    else            return EVT_NONE;
  endfunction

endpackage

// File: rtl/digit_entry_controller_edge_pulse.sv
// Rising-edge detector for one synchronised button level.
//   CLK     : system clock
//   CLR     : async active-high reset
//   i_level : synchronised button level
//   o_pulse : high for the cycle in which i_level is 1 and was 0 at the previous edge
// The history flop resets to 1 so a button held through reset never fires.
module edge_pulse (
  input  logic CLK,
  input  logic CLR,
  input  logic i_level,
  output logic o_pulse
);

  logic r_prev;

  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) r_prev <= 1'b1;
    else     r_prev <= i_level;
  end

  assign o_pulse = i_level & ~r_prev;

endmodule

// File: rtl/digit_entry_controller.sv
// Sequences a bank of SLOTS registers from one shared switch bus.
//   CLK, CLR    : clock, async active-high reset
//   btn_enter   : rising edge loads D_in into the next free slot
//   btn_back    : rising edge clears the most recently loaded slot
//   btn_clear   : rising edge clears every slot
//   D_in        : switch value
//   D_out       : registered copy of D_in, shared D of all slots
//   slot_enter  : one-hot 1-cycle load strobe
//   slot_clr    : 1-cycle clear strobe (one-hot for back, all ones for clear)
//   count       : slots currently loaded, 0..SLOTS
//   full        : count == SLOTS
//   overflow    : 1-cycle pulse on enter while full
// Events are registered once (r_evt) at the detecting edge and acted on at
// the next edge, so every strobe appears one cycle after its button edge.
module digit_entry_controller
  import digit_entry_pkg::*;
#(
  parameter  int WIDTH = 4,
  parameter  int SLOTS = 4,
  localparam int CW    = $clog2(SLOTS + 1)
) (
  input  logic             CLK,
  input  logic             CLR,
  input  logic             btn_enter,
  input  logic             btn_back,
  input  logic             btn_clear,
  input  logic [WIDTH-1:0] D_in,
  output logic [WIDTH-1:0] D_out,
  output logic [SLOTS-1:0] slot_enter,
  output logic [SLOTS-1:0] slot_clr,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             overflow
);

  localparam logic [CW-1:0]    C_SLOTS = CW'(SLOTS);
  localparam logic [SLOTS-1:0] C_ONE   = SLOTS'(1);

  logic w_rise_enter, w_rise_back, w_rise_clear;
  evt_t w_evt;

  state_t           r_state, w_state_nxt;
  evt_t             r_evt;
  logic [CW-1:0]    r_count, w_count_nxt;
  logic [WIDTH-1:0] r_dout;
  logic [SLOTS-1:0] r_slot_enter, w_slot_enter_nxt;
  logic [SLOTS-1:0] r_slot_clr, w_slot_clr_nxt;
  logic             r_overflow, w_overflow_nxt;
  logic [CW-1:0]    w_count_inc, w_count_dec;

  edge_pulse u_ep_enter (.CLK(CLK), .CLR(CLR), .i_level(btn_enter), .o_pulse(w_rise_enter));
  edge_pulse u_ep_back  (.CLK(CLK), .CLR(CLR), .i_level(btn_back),  .o_pulse(w_rise_back));
  edge_pulse u_ep_clear (.CLK(CLK), .CLR(CLR), .i_level(btn_clear), .o_pulse(w_rise_clear));

  assign w_evt       = encode_evt(w_rise_clear, w_rise_back, w_rise_enter);
  assign w_count_inc = r_count + CW'(1);
  assign w_count_dec = r_count - CW'(1);

  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      r_state      <= EMPTY;
      r_evt        <= EVT_NONE;
      r_count      <= '0;
      r_dout       <= '0;
      r_slot_enter <= '0;
      r_slot_clr   <= '0;
      r_overflow   <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_evt        <= w_evt;
      r_count      <= w_count_nxt;
      r_slot_enter <= w_slot_enter_nxt;
      r_slot_clr   <= w_slot_clr_nxt;
      r_overflow   <= w_overflow_nxt;
      // Captured with the winning enter so it is already stable when the
      // load strobe rises one cycle later.
      if (w_evt == EVT_ENTER) r_dout <= D_in;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_count_nxt      = r_count;
    w_slot_enter_nxt = '0;
    w_slot_clr_nxt   = '0;
    w_overflow_nxt   = 1'b0;
    unique case (r_state)
      EMPTY: begin
        if (r_evt == EVT_CLEAR) begin
          w_state_nxt    = CLEARING;
          w_slot_clr_nxt = '1;
          w_count_nxt    = '0;
        end else if (r_evt == EVT_ENTER) begin
          w_slot_enter_nxt = C_ONE;
          w_count_nxt      = CW'(1);
          w_state_nxt      = (C_SLOTS == CW'(1)) ? FULL : ENTRY;
        end
      end
      ENTRY: begin
        if (r_evt == EVT_CLEAR) begin
          w_state_nxt    = CLEARING;
          w_slot_clr_nxt = '1;
          w_count_nxt    = '0;
        end else if (r_evt == EVT_BACK) begin
          w_slot_clr_nxt = C_ONE << w_count_dec;
          w_count_nxt    = w_count_dec;
          w_state_nxt    = (w_count_dec == '0) ? EMPTY : ENTRY;
        end else if (r_evt == EVT_ENTER) begin
          w_slot_enter_nxt = C_ONE << r_count;
          w_count_nxt      = w_count_inc;
          w_state_nxt      = (w_count_inc == C_SLOTS) ? FULL : ENTRY;
        end
      end
      FULL: begin
        if (r_evt == EVT_CLEAR) begin
          w_state_nxt    = CLEARING;
          w_slot_clr_nxt = '1;
          w_count_nxt    = '0;
        end else if (r_evt == EVT_BACK) begin
          w_slot_clr_nxt = C_ONE << (C_SLOTS - CW'(1));
          w_count_nxt    = C_SLOTS - CW'(1);
          w_state_nxt    = ENTRY;
        end else if (r_evt == EVT_ENTER) begin
          w_overflow_nxt = 1'b1;
        end
      end
      CLEARING: begin
        // The all-ones strobe was issued on entry; events arriving now are dropped.
        w_state_nxt = EMPTY;
      end
      default: w_state_nxt = EMPTY;
    endcase
  end

  assign D_out      = r_dout;
  assign slot_enter = r_slot_enter;
  assign slot_clr   = r_slot_clr;
  assign count      = r_count;
  assign overflow   = r_overflow;
  assign full       = (r_state == FULL);

endmodule

// File: tb/tb_digit_entry_controller.sv
module tb_digit_entry_controller;

  localparam int WIDTH = 4;
  localparam int SLOTS = 4;
  localparam int CW    = 3;

  logic             CLK = 1'b0;
  logic             CLR;
  logic             btn_enter, btn_back, btn_clear;
  logic [WIDTH-1:0] D_in;
  logic [WIDTH-1:0] D_out;
  logic [SLOTS-1:0] slot_enter, slot_clr;
  logic [CW-1:0]    count;
  logic             full, overflow;

  digit_entry_controller #(.WIDTH(WIDTH), .SLOTS(SLOTS)) dut (
    .CLK(CLK), .CLR(CLR),
    .btn_enter(btn_enter), .btn_back(btn_back), .btn_clear(btn_clear),
    .D_in(D_in), .D_out(D_out),
    .slot_enter(slot_enter), .slot_clr(slot_clr),
    .count(count), .full(full), .overflow(overflow)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [SLOTS-1:0] en;
    logic [SLOTS-1:0] clr;
    logic             ovf;
    logic [CW-1:0]    cnt;
    logic             full;
    logic [WIDTH-1:0] dout;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   fails  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic [SLOTS-1:0] en, input logic [SLOTS-1:0] clr, input logic ovf,
                      input logic [CW-1:0] cnt, input logic f, input logic [WIDTH-1:0] d);
    exp_t e;
    e.en = en; e.clr = clr; e.ovf = ovf; e.cnt = cnt; e.full = f; e.dout = d;
    sb.push_back(e);
  endtask

  // One-cycle press of any combination of buttons, then idle long enough
  // for the resulting strobe to appear and retire.
  task automatic press(input logic e, input logic b, input logic c, input logic [WIDTH-1:0] d);
    @(negedge CLK);
    D_in = d; btn_enter = e; btn_back = b; btn_clear = c;
    @(negedge CLK);
    btn_enter = 1'b0; btn_back = 1'b0; btn_clear = 1'b0;
    repeat (3) @(negedge CLK);
  endtask

  // Monitor: any strobe is an output event and must match the queue head.
  always @(negedge CLK) begin
    if (CLR === 1'b0 && (slot_enter != '0 || slot_clr != '0 || overflow)) begin
      chk("strobe_exclusive", {31'd0, (slot_enter != '0) && (slot_clr != '0)}, 32'd0);
      if (sb.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL unexpected_strobe: got en=%b clr=%b ovf=%b, expected no strobe", slot_enter, slot_clr, overflow);
      end else begin
        mon_e = sb.pop_front();
        chk("slot_enter", 32'(slot_enter), 32'(mon_e.en));
        chk("slot_clr",   32'(slot_clr),   32'(mon_e.clr));
        chk("overflow",   32'(overflow),   32'(mon_e.ovf));
        chk("count",      32'(count),      32'(mon_e.cnt));
        chk("full",       32'(full),       32'(mon_e.full));
        chk("D_out",      32'(D_out),      32'(mon_e.dout));
      end
    end
  end

  logic [WIDTH-1:0] vals [4];
  bit               seen;

  initial begin
    vals[0] = 4'h3; vals[1] = 4'h7; vals[2] = 4'hA; vals[3] = 4'hF;
    CLR = 1'b1; btn_enter = 1'b1; btn_back = 1'b0; btn_clear = 1'b0; D_in = '0;
    repeat (2) @(negedge CLK);
    chk("rst_slot_enter", 32'(slot_enter), 32'd0);
    chk("rst_slot_clr",   32'(slot_clr),   32'd0);
    chk("rst_overflow",   32'(overflow),   32'd0);
    chk("rst_full",       32'(full),       32'd0);
    chk("rst_count",      32'(count),      32'd0);
    chk("rst_D_out",      32'(D_out),      32'd0);

    // Button held through reset release must not fire.
    CLR = 1'b0;
    repeat (4) @(negedge CLK);
    chk("held_count", 32'(count), 32'd0);
    btn_enter = 1'b0;
    @(negedge CLK);

    push(4'b0001, 4'b0000, 1'b0, 3'd1, 1'b0, 4'h5);
    press(1'b1, 1'b0, 1'b0, 4'h5);
    push(4'b0000, 4'b0001, 1'b0, 3'd0, 1'b0, 4'h5);
    press(1'b0, 1'b1, 1'b0, 4'h5);

    for (int i = 0; i < 4; i++) begin
      push(SLOTS'(1) << i, 4'b0000, 1'b0, CW'(i + 1), (i == 3), vals[i]);
      press(1'b1, 1'b0, 1'b0, vals[i]);
    end
    chk("full_after_4", 32'(full), 32'd1);

    push(4'b0000, 4'b0000, 1'b1, 3'd4, 1'b1, 4'hF);
    press(1'b1, 1'b0, 1'b0, 4'hF);

    push(4'b0000, 4'b1000, 1'b0, 3'd3, 1'b0, 4'hF);
    press(1'b0, 1'b1, 1'b0, 4'h0);
    push(4'b0000, 4'b0100, 1'b0, 3'd2, 1'b0, 4'hF);
    press(1'b0, 1'b1, 1'b0, 4'h0);
    push(4'b0000, 4'b0010, 1'b0, 3'd1, 1'b0, 4'hF);
    press(1'b0, 1'b1, 1'b0, 4'h0);
    push(4'b0000, 4'b0001, 1'b0, 3'd0, 1'b0, 4'hF);
    press(1'b0, 1'b1, 1'b0, 4'h0);
    // Back while empty: no strobe, count stays 0.
    press(1'b0, 1'b1, 1'b0, 4'h0);
    chk("back_empty_count", 32'(count), 32'd0);

    push(4'b0001, 4'b0000, 1'b0, 3'd1, 1'b0, 4'h9);
    press(1'b1, 1'b0, 1'b0, 4'h9);
    push(4'b0010, 4'b0000, 1'b0, 3'd2, 1'b0, 4'h6);
    press(1'b1, 1'b0, 1'b0, 4'h6);
    // Enter and clear on the same edge: clear wins, D_out holds.
    push(4'b0000, 4'b1111, 1'b0, 3'd0, 1'b0, 4'h6);
    press(1'b1, 1'b0, 1'b1, 4'hB);
    push(4'b0001, 4'b0000, 1'b0, 3'd1, 1'b0, 4'hC);
    press(1'b1, 1'b0, 1'b0, 4'hC);

    // Async reset while slot_enter=0010 is high.
    @(negedge CLK);
    D_in = 4'hD; btn_enter = 1'b1;
    @(negedge CLK);
    btn_enter = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin
      @(posedge CLK);
      #1;
      if (slot_enter != '0) seen = 1'b1;
    end
    chk("strobe_seen", 32'(seen), 32'd1);
    chk("pre_rst_slot_enter", 32'(slot_enter), 32'b0010);
    chk("pre_rst_count",      32'(count),      32'd2);
    chk("pre_rst_D_out",      32'(D_out),      32'hD);
    #1 CLR = 1'b1;
    #1;
    chk("async_slot_enter", 32'(slot_enter), 32'd0);
    chk("async_count",      32'(count),      32'd0);
    chk("async_full",       32'(full),       32'd0);
    chk("async_D_out",      32'(D_out),      32'd0);
    @(negedge CLK);
    CLR = 1'b0;
    repeat (3) @(negedge CLK);

    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/digit_entry_controller.md
Name: digit_entry_controller

Overview:
- Sequencer that fills a bank of SLOTS Register instances, each WIDTH bits wide, from one shared switch bus D_in.
- Drives each slot's per-register enter and CLR strobes from three user buttons: enter, back (delete last) and clear-all.
- Tracks a fill count and a full flag for display logic, such as seven-segment or LEDs.
- Sits between the button synchronisers/debouncers and the register bank in top-level lab designs.

Parameters:
- WIDTH, 4, data width of each slot and of D_in/D_out.
- SLOTS, 4, number of registers sequenced (2..16).
- CW, $clog2(SLOTS+1), width of count; derived, not overridden.

Ports:
- CLK  input  1  system clock, rising-edge.
- CLR  input  1  asynchronous, active-high reset.
- btn_enter  input  1  synchronised, debounced level; rising edge requests load of D_in into the next slot.
- btn_back  input  1  synchronised level; rising edge clears the most recently loaded slot.
- btn_clear  input  1  synchronised level; rising edge clears all slots.
- D_in  input  WIDTH  switch value to store.
- D_out  output  WIDTH  registered copy of D_in; wired to D of every slot.
- slot_enter  output  SLOTS  one-hot, 1-cycle load strobe, to each slot's enter.
- slot_clr  output  SLOTS  1-cycle clear strobe, to each slot's CLR; one-hot for back, all ones for clear.
- count  output  CW  number of slots currently loaded, 0..SLOTS.
- full  output  1  high when count==SLOTS.
- overflow  output  1  1-cycle pulse when enter is requested while FULL.

Behaviour:
- Reset (async, CLR=1):
  - State is EMPTY and count=0.
  - slot_enter=0, slot_clr=0, overflow=0, full=0, D_out=0.
  - The edge-detector previous-value flops reset to 1, so a button held through reset produces no event.
- Edge detect:
  - An event fires on edge n when the input is high at edge n and was low at edge n-1.
  - Each event is used exactly once.
- Latency: every output is registered. An event sampled at edge n gives its strobe high from edge n+1 to n+2, exactly one cycle wide.
- D_out: captured at the same edge as the enter event, so it is stable while slot_enter is high. It holds otherwise.
- Priority when events coincide on the same edge: clear > back > enter. Lower-priority events on that edge are dropped, not queued.
- FSM states: EMPTY, ENTRY, FULL, CLEARING. Type state_t.
- EMPTY:
  - enter: slot_enter[0], count becomes 1, next state ENTRY (FULL if SLOTS==1).
  - back: ignored, no strobe.
  - clear: go to CLEARING.
- ENTRY:
  - enter: slot_enter[count], count+1; go to FULL if the new count==SLOTS.
  - back: slot_clr[count-1], count-1; go to EMPTY if the new count==0.
  - clear: go to CLEARING.
- FULL:
  - enter: no slot_enter; overflow pulses; count is unchanged.
  - back: slot_clr[SLOTS-1], count becomes SLOTS-1, next state ENTRY.
  - clear: go to CLEARING.
- CLEARING: lasts exactly one cycle.
  - slot_clr is all ones and count becomes 0.
  - Next state EMPTY unconditionally.
  - Button events sampled during CLEARING are dropped, but edge-detect history still updates.
- full is decoded from the registered state (FULL) and is coincident with count==SLOTS.
- Invariants:
  - slot_enter and slot_clr are never both nonzero in the same cycle.
  - count never exceeds SLOTS and never wraps below 0.
- Reset mid-operation: outputs go to reset values immediately. Any strobe in flight is cut short.

Decomposition:
- Package digit_entry_pkg holds:
  - typedef enum logic [1:0] state_t {EMPTY, ENTRY, FULL, CLEARING}.
  - localparam priority encoding for the event type.
- Sub-module edge_pulse (CLK, CLR, level in, 1-cycle pulse out; prev flop resets to 1). Instantiated three times, once per button.
- Next-state logic and the count/strobe logic stay in the top module.

Test Plan (WIDTH=4, SLOTS=4):
- Reset with btn_enter held high, then release and press once → no strobe while held. The press gives slot_enter=0001 one cycle after the edge, D_out=D_in (0x5), count=1.
- Four enters with D_in=3,7,A,F → slot_enter 0001,0010,0100,1000 in turn, each with the matching D_out. count=4, full=1.
- A fifth enter while FULL → overflow high one cycle, slot_enter=0, count stays 4.
- From count=3, press back, then back again → slot_clr 0100 then 0010, count 2 then 1. Back at count=0 → no strobe, count stays 0.
- btn_enter and btn_clear rising on the same edge at count=2 → slot_clr=1111 for one cycle, no slot_enter, count=0, state EMPTY.
- Assert CLR asynchronously during the cycle slot_enter=0010 is high → slot_enter drops to 0 before the next CLK edge, count=0, full=0.
